ghost_mode_scheduler: RTL and testbench
=======================================

Name: ghost_mode_scheduler

Overview:
Central sequencer for the four ghost AI blocks (Blinky, Pinky, Inky, Clyde).
- Generates the shared update strobe the ghost blocks use as their evaluate edge.
- Runs the global scatter/chase phase schedule and the frightened timer triggered by a power pellet.
- Tracks per-ghost Eaten state.
- Drives each ghost's one-hot mode and its rotate (reverse) request.

Parameters:
TICK_DIV, 4, clk cycles per update period; even, >=2
SCATTER_TICKS, 7, update periods per scatter phase
CHASE_TICKS, 20, update periods per chase phase
FRIGHT_TICKS, 6, update periods of frightened mode per pellet
PHASES, 4, scatter phases before chase becomes permanent (1..7)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = schedule runs; 0 = divider and all timers frozen, outputs held
pellet_i  in  1  one-cycle pulse: power pellet eaten
eaten_i  in  4  per-ghost pulse: pacman collided with ghost g
home_i  in  4  per-ghost pulse: eaten ghost g reached ghost house
update_o  out  1  ghost update strobe, 50% duty, period TICK_DIV clks
mode_o  out  16  {g3,g2,g1,g0} one-hot: 1000 Chase, 0100 Scatter, 0010 Frightened, 0001 Eaten
rotate_o  out  4  per-ghost reverse request
fright_o  out  1  global frightened active
phase_o  out  3  current scatter/chase phase index

Behaviour:
- Reset values: update_o=0, mode_o=16'h4444, rotate_o=0, fright_o=0, phase_o=0, all counters 0, all latches cleared.
- Divider: cnt counts 0..TICK_DIV-1 while enable=1. update_o = (cnt >= TICK_DIV/2), registered.
- Boundary: the cycle cnt wraps to 0, i.e. update_o falls. Every state or output change except update_o occurs only at a boundary, so mode_o and rotate_o are stable across a full update period.
- Input latches: pellet_i, eaten_i and home_i pulses arriving in any enabled or disabled cycle are latched. They are consumed at the next boundary, and the latch clears at that boundary.
- Global FSM states: SCATTER, CHASE, FRIGHT. ph_cnt counts boundaries in the current phase.
- SCATTER: when ph_cnt reaches SCATTER_TICKS-1 -> CHASE, ph_cnt=0, rotate.
- CHASE with phase_o < PHASES-1: when ph_cnt reaches CHASE_TICKS-1 -> SCATTER, phase_o+1, ph_cnt=0, rotate.
- CHASE with phase_o = PHASES-1: permanent; ph_cnt saturates.
- Pellet at a boundary while in SCATTER or CHASE:
  - Process the phase step first.
  - Save the resulting state and ph_cnt, then enter FRIGHT with fr_cnt=FRIGHT_TICKS-1.
  - fright_o=1; rotate. Only one rotate is issued even if the phase step also rotated.
- Pellet while in FRIGHT: reload fr_cnt, clear all immune flags, no rotate.
- FRIGHT counts down fr_cnt. The boundary where fr_cnt=0 restores the saved state and ph_cnt: fright_o=0, no rotate. The phase timer stays paused throughout FRIGHT.
- Per ghost g: eaten flag E[g] and immune flag I[g].
  - eaten_i[g] is honoured only if ghost g currently shows Frightened. It sets E[g]; otherwise it is ignored.
  - home_i[g] with E[g]=1 clears E[g]. If global state is FRIGHT, it also sets I[g].
  - eaten and home latched in the same period: eaten wins, home discarded.
  - I[g] clears when FRIGHT ends or a new pellet arrives.
- mode for ghost g:
  - E[g] -> Eaten.
  - else FRIGHT and !I[g] -> Frightened.
  - else FRIGHT and I[g] -> saved state encoding.
  - else current global state encoding.
- rotate_o[g]: set at a rotate boundary for ghosts not in Eaten; cleared at the next boundary, i.e. held exactly one update period.
- reset overrides everything in the same cycle, including mid-FRIGHT and mid-period; no pending latch survives reset.

Optional Feature:
GHOST_FRIGHT_WARN_EN
- Defined: adds output fright_warn_o (1 bit) and parameter WARN_TICKS (default 2). fright_warn_o=1 while fright_o=1 and fr_cnt < WARN_TICKS; it changes at boundaries and resets to 0. Used for ghost flashing.
- Undefined: the port and parameter are absent; behaviour is otherwise identical.

Test Plan (defaults):
- Reset release, enable=1 -> update_o first rises at clk 2, period 4; mode_o=16'h4444 for 7 boundaries; at boundary 7 (clk 28) mode_o=16'h8888 and rotate_o=4'hF for exactly 4 clks, then 0.
- pellet_i pulse during scatter period 3 -> next boundary mode_o=16'h2222, rotate_o=4'hF, fright_o=1; after 6 periods mode_o=16'h4444, and CHASE begins after 4 further periods (7 scatter periods total).
- In FRIGHT, eaten_i=4'h2 -> mode_o=16'h2212; home_i=4'h2 -> mode_o=16'h2242; at fright end -> 16'h4444.
- eaten_i=4'h1 during SCATTER -> ignored, mode_o stays 16'h4444.
- Run 4 scatter/chase cycles -> phase_o reaches 3, mode_o=16'h8888 permanently with no further rotate.
- reset high mid-FRIGHT with pending pellet -> next clk mode_o=16'h4444, fright_o=0, rotate_o=0, update_o=0.

Source files
------------

// File: rtl/ghost_mode_scheduler.sv
// Ghost sequencer: update strobe, scatter/chase/fright schedule, per-ghost eaten state.
// Optional GHOST_FRIGHT_WARN_EN adds fright_warn_o and WARN_TICKS.
module ghost_mode_scheduler #(
  parameter int TICK_DIV      = 4,
  parameter int SCATTER_TICKS = 7,
  parameter int CHASE_TICKS   = 20,
  parameter int FRIGHT_TICKS  = 6,
  parameter int PHASES        = 4
`ifdef GHOST_FRIGHT_WARN_EN
  ,
  parameter int WARN_TICKS    = 2
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pellet_i,
  input  logic [3:0]  eaten_i,
  input  logic [3:0]  home_i,
  output logic        update_o,
  output logic [15:0] mode_o,
  output logic [3:0]  rotate_o,
  output logic        fright_o,
  output logic [2:0]  phase_o
`ifdef GHOST_FRIGHT_WARN_EN
  ,
  output logic        fright_warn_o
`endif
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);
  localparam logic [15:0]   SC_LAST  = 16'(SCATTER_TICKS - 1);
  localparam logic [15:0]   CH_LAST  = 16'(CHASE_TICKS - 1);
  localparam logic [15:0]   FR_LOAD  = 16'(FRIGHT_TICKS - 1);
  localparam logic [2:0]    PH_LAST  = 3'(PHASES - 1);

  typedef enum logic [1:0] {
    ST_SCATTER = 2'd0,
    ST_CHASE   = 2'd1,
    ST_FRIGHT  = 2'd2
  } state_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          upd_q, upd_d;
  state_e        state_q, state_d;
  state_e        saved_q, saved_d;
  logic [15:0]   ph_q, ph_d;
  logic [15:0]   phsv_q, phsv_d;
  logic [15:0]   fr_q, fr_d;
  logic [2:0]    phase_q, phase_d;
  logic [3:0]    e_q, e_d;
  logic [3:0]    i_q, i_d;
  logic [3:0]    rot_q, rot_d;
  logic          pel_q, pel_d;
  logic [3:0]    eat_q, eat_d;
  logic [3:0]    home_q, home_d;

  logic          bnd;
  logic          pel_eff;
  logic [3:0]    eat_eff;
  logic [3:0]    home_eff;
  logic [3:0]    fr_show;
  state_e        st_step;
  logic [15:0]   ph_step;
  logic          rot_ev;

  function automatic logic [3:0] enc(input state_e s);
    logic [3:0] r;
    unique case (s)
      ST_CHASE:  r = 4'b1000;
      ST_FRIGHT: r = 4'b0010;
      default:   r = 4'b0100;
    endcase
    return r;
  endfunction

  always_comb begin
    bnd      = enable && (cnt_q == CNT_LAST);
    pel_eff  = pel_q | pellet_i;
    eat_eff  = eat_q | eaten_i;
    home_eff = home_q | home_i;
    for (int g = 0; g < 4; g++) begin
      fr_show[g] = (state_q == ST_FRIGHT) && !e_q[g] && !i_q[g];
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    upd_d   = upd_q;
    state_d = state_q;
    saved_d = saved_q;
    ph_d    = ph_q;
    phsv_d  = phsv_q;
    fr_d    = fr_q;
    phase_d = phase_q;
    e_d     = e_q;
    i_d     = i_q;
    rot_d   = rot_q;
    pel_d   = pel_eff;
    eat_d   = eat_eff;
    home_d  = home_eff;
    st_step = state_q;
    ph_step = ph_q;
    rot_ev  = 1'b0;
    if (enable) begin
      cnt_d = bnd ? '0 : cnt_q + CW'(1);
      upd_d = (cnt_d >= CNT_HALF);
    end
    if (bnd) begin
      pel_d  = 1'b0;
      eat_d  = '0;
      home_d = '0;
      rot_d  = '0;
      for (int g = 0; g < 4; g++) begin
        if (eat_eff[g]) begin
          if (fr_show[g]) e_d[g] = 1'b1;
        end else if (home_eff[g] && e_q[g]) begin
          e_d[g] = 1'b0;
          if (state_q == ST_FRIGHT) i_d[g] = 1'b1;
        end
      end
      if (state_q == ST_FRIGHT) begin
        if (pel_eff) begin
          fr_d = FR_LOAD;
          i_d  = '0;
        end else if (fr_q == 16'd0) begin
          state_d = saved_q;
          ph_d    = phsv_q;
          i_d     = '0;
        end else begin
          fr_d = fr_q - 16'd1;
        end
      end else begin
        if (state_q == ST_SCATTER) begin
          if (ph_q == SC_LAST) begin
            st_step = ST_CHASE;
            ph_step = '0;
            rot_ev  = 1'b1;
          end else begin
            ph_step = ph_q + 16'd1;
          end
        end else if (phase_q < PH_LAST) begin
          if (ph_q == CH_LAST) begin
            st_step = ST_SCATTER;
            ph_step = '0;
            phase_d = phase_q + 3'd1;
            rot_ev  = 1'b1;
          end else begin
            ph_step = ph_q + 16'd1;
          end
        end else if (ph_q != CH_LAST) begin
          ph_step = ph_q + 16'd1;
        end
        state_d = st_step;
        ph_d    = ph_step;
        // a pellet freezes the post-step schedule and resumes it when fright ends
        if (pel_eff) begin
          saved_d = st_step;
          phsv_d  = ph_step;
          state_d = ST_FRIGHT;
          fr_d    = FR_LOAD;
          i_d     = '0;
          rot_ev  = 1'b1;
        end
      end
      if (rot_ev) rot_d = ~e_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      state_q <= ST_SCATTER;
      saved_q <= ST_SCATTER;
      ph_q    <= '0;
      phsv_q  <= '0;
      fr_q    <= '0;
      phase_q <= '0;
      e_q     <= '0;
      i_q     <= '0;
      rot_q   <= '0;
      pel_q   <= 1'b0;
      eat_q   <= '0;
      home_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      state_q <= state_d;
      saved_q <= saved_d;
      ph_q    <= ph_d;
      phsv_q  <= phsv_d;
      fr_q    <= fr_d;
      phase_q <= phase_d;
      e_q     <= e_d;
      i_q     <= i_d;
      rot_q   <= rot_d;
      pel_q   <= pel_d;
      eat_q   <= eat_d;
      home_q  <= home_d;
    end
  end

`ifdef GHOST_FRIGHT_WARN_EN
  logic warn_q, warn_d;

  always_comb begin
    warn_d = warn_q;
    if (bnd) warn_d = (state_d == ST_FRIGHT) && (fr_d < 16'(WARN_TICKS));
  end

  always_ff @(posedge clk) begin
    if (reset) warn_q <= 1'b0;
    else       warn_q <= warn_d;
  end

  assign fright_warn_o = warn_q;
`endif

  always_comb begin
    mode_o = '0;
    for (int g = 0; g < 4; g++) begin
      if (e_q[g])                  mode_o[g*4 +: 4] = 4'b0001;
      else if (fr_show[g])         mode_o[g*4 +: 4] = 4'b0010;
      else if (state_q == ST_FRIGHT) mode_o[g*4 +: 4] = enc(saved_q);
      else                         mode_o[g*4 +: 4] = enc(state_q);
    end
  end

  assign update_o = upd_q;
  assign rotate_o = rot_q;
  assign fright_o = (state_q == ST_FRIGHT);
  assign phase_o  = phase_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Randomised and directed bench for ghost_mode_scheduler against a period-level model.
`timescale 1ns/1ps
module tb_ghost_mode_scheduler;

  localparam int TD = 4;
  localparam int SC = 7;
  localparam int CH = 20;
  localparam int FT = 6;
  localparam int PH = 4;
`ifdef GHOST_FRIGHT_WARN_EN
  localparam int WT = 2;
  localparam int OW = 26;
  localparam logic [OW-1:0] RST_OBS = {1'b0, 16'h4444, 4'h0, 1'b0, 3'd0, 1'b0};
`else
  localparam int OW = 25;
  localparam logic [OW-1:0] RST_OBS = {1'b0, 16'h4444, 4'h0, 1'b0, 3'd0};
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pellet_i = 1'b0;
  logic [3:0]  eaten_i = 4'h0;
  logic [3:0]  home_i = 4'h0;
  logic        update_o;
  logic [15:0] mode_o;
  logic [3:0]  rotate_o;
  logic        fright_o;
  logic [2:0]  phase_o;
  logic [OW-1:0] obs;

`ifdef GHOST_FRIGHT_WARN_EN
  logic fright_warn_o;
  assign obs = {update_o, mode_o, rotate_o, fright_o, phase_o, fright_warn_o};
`else
  assign obs = {update_o, mode_o, rotate_o, fright_o, phase_o};
`endif

  ghost_mode_scheduler #(
    .TICK_DIV(TD), .SCATTER_TICKS(SC), .CHASE_TICKS(CH),
    .FRIGHT_TICKS(FT), .PHASES(PH)
`ifdef GHOST_FRIGHT_WARN_EN
    , .WARN_TICKS(WT)
`endif
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pellet_i(pellet_i), .eaten_i(eaten_i), .home_i(home_i),
    .update_o(update_o), .mode_o(mode_o), .rotate_o(rotate_o),
    .fright_o(fright_o), .phase_o(phase_o)
`ifdef GHOST_FRIGHT_WARN_EN
    , .fright_warn_o(fright_warn_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 scatter, 1 chase, 2 fright; "left" = periods remaining in phase.
  int m_div, m_st, m_saved, m_left, m_sleft, m_fleft, m_phase;
  bit m_upd, l_pel;
  bit [3:0] m_E, m_I, m_rot, l_eat, l_home;

  function automatic logic [3:0] m_nib(input int s);
    if (s == 1) return 4'h8;
    if (s == 2) return 4'h2;
    return 4'h4;
  endfunction

  function automatic logic [OW-1:0] m_outs();
    logic [15:0] md;
    for (int g = 0; g < 4; g++) begin
      if (m_E[g])                 md[g*4 +: 4] = 4'h1;
      else if (m_st == 2 && !m_I[g]) md[g*4 +: 4] = 4'h2;
      else if (m_st == 2)         md[g*4 +: 4] = m_nib(m_saved);
      else                        md[g*4 +: 4] = m_nib(m_st);
    end
`ifdef GHOST_FRIGHT_WARN_EN
    return {m_upd, md, m_rot, m_st == 2, 3'(m_phase), (m_st == 2 && m_fleft <= WT)};
`else
    return {m_upd, md, m_rot, m_st == 2, 3'(m_phase)};
`endif
  endfunction

  task automatic m_apply(input bit r, input bit en, input bit p,
                         input bit [3:0] e, input bit [3:0] h);
    bit bnd, rot;
    bit [3:0] shows;
    if (r) begin
      m_div = 0; m_upd = 0; m_st = 0; m_saved = 0; m_left = SC; m_sleft = SC;
      m_fleft = 0; m_phase = 0; m_E = 0; m_I = 0; m_rot = 0;
      l_pel = 0; l_eat = 0; l_home = 0;
      return;
    end
    l_pel |= p; l_eat |= e; l_home |= h;
    if (!en) return;
    bnd = (m_div == TD - 1);
    m_div = (m_div + 1) % TD;
    m_upd = (m_div >= TD / 2);
    if (!bnd) return;
    rot = 0;
    for (int g = 0; g < 4; g++) shows[g] = (m_st == 2) && !m_E[g] && !m_I[g];
    for (int g = 0; g < 4; g++) begin
      if (l_eat[g]) begin
        if (shows[g]) m_E[g] = 1;
      end else if (l_home[g] && m_E[g]) begin
        m_E[g] = 0;
        if (m_st == 2) m_I[g] = 1;
      end
    end
    if (m_st == 2) begin
      if (l_pel) begin
        m_fleft = FT; m_I = 0;
      end else begin
        m_fleft--;
        if (m_fleft == 0) begin m_st = m_saved; m_left = m_sleft; m_I = 0; end
      end
    end else begin
      if (!(m_st == 1 && m_phase == PH - 1)) begin
        m_left--;
        if (m_left == 0) begin
          if (m_st == 0) begin m_st = 1; m_left = CH; end
          else begin m_st = 0; m_left = SC; m_phase++; end
          rot = 1;
        end
      end
      if (l_pel) begin
        m_saved = m_st; m_sleft = m_left; m_st = 2; m_fleft = FT; m_I = 0; rot = 1;
      end
    end
    m_rot = rot ? ~m_E : 4'h0;
    l_pel = 0; l_eat = 0; l_home = 0;
  endtask

  task automatic cyc(input bit r, input bit en, input bit p,
                     input bit [3:0] e, input bit [3:0] h);
    @(negedge clk);
    reset = r; enable = en; pellet_i = p; eaten_i = e; home_i = h;
    @(posedge clk);
    m_apply(r, en, p, e, h);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 1, 4'hF, 4'hF);
    cyc(1, 1, 0, 4'h0, 4'h0);
    if (obs !== RST_OBS) begin
      errors++; $display("FAIL reset_const got %h exp %h", obs, RST_OBS);
    end
    checks++;
    if (obs !== m_outs()) begin
      errors++; $display("FAIL reset_model got %h exp %h", obs, m_outs());
    end
    checks++;
  endtask

  task automatic test_schedule();
    for (int n = 1; n <= 40; n++) begin
      cyc(0, 1, 0, 4'h0, 4'h0);
      if (obs !== m_outs()) begin
        errors++; $display("FAIL schedule clk %0d got %h exp %h", n, obs, m_outs());
      end
      checks++;
      if (n == 1 || n == 2) begin
        if (update_o !== (n == 2)) begin
          errors++; $display("FAIL first_rise clk %0d got %b exp %b", n, update_o, n == 2);
        end
        checks++;
      end
      if (n == 27 || n == 28) begin
        if (mode_o !== ((n == 28) ? 16'h8888 : 16'h4444)) begin
          errors++; $display("FAIL chase_entry clk %0d got %h", n, mode_o);
        end
        checks++;
      end
      if (n >= 28 && n <= 32) begin
        if (rotate_o !== ((n < 32) ? 4'hF : 4'h0)) begin
          errors++; $display("FAIL rotate_hold clk %0d got %h", n, rotate_o);
        end
        checks++;
      end
    end
  endtask

  task automatic test_pellet();
    cyc(1, 1, 0, 4'h0, 4'h0);
    for (int n = 1; n <= 56; n++) begin
      cyc(0, 1, n == 10, 4'h0, 4'h0);
      if (obs !== m_outs()) begin
        errors++; $display("FAIL pellet clk %0d got %h exp %h", n, obs, m_outs());
      end
      checks++;
      if (n == 12) begin
        if ({mode_o, rotate_o, fright_o} !== {16'h2222, 4'hF, 1'b1}) begin
          errors++; $display("FAIL fright_entry got %h/%h/%b exp 2222/f/1", mode_o, rotate_o, fright_o);
        end
        checks++;
      end
      if (n == 36 || n == 51) begin
        if ({mode_o, rotate_o, fright_o} !== {16'h4444, 4'h0, 1'b0}) begin
          errors++; $display("FAIL fright_exit clk %0d got %h/%h/%b exp 4444/0/0", n, mode_o, rotate_o, fright_o);
        end
        checks++;
      end
      if (n == 52) begin
        if (mode_o !== 16'h8888) begin
          errors++; $display("FAIL resumed_chase got %h exp 8888", mode_o);
        end
        checks++;
      end
    end
  endtask

  task automatic test_eaten();
    cyc(1, 1, 0, 4'h0, 4'h0);
    for (int n = 1; n <= 32; n++) begin
      cyc(0, 1, n == 2, (n == 5) ? 4'h2 : 4'h0, (n == 9) ? 4'h2 : 4'h0);
      if (obs !== m_outs()) begin
        errors++; $display("FAIL eaten clk %0d got %h exp %h", n, obs, m_outs());
      end
      checks++;
      if (n == 8 || n == 12 || n == 28) begin
        if (mode_o !== ((n == 8) ? 16'h2212 : (n == 12) ? 16'h2242 : 16'h4444)) begin
          errors++; $display("FAIL eaten_mode clk %0d got %h", n, mode_o);
        end
        checks++;
      end
    end
  endtask

  task automatic test_ignored_eaten();
    cyc(1, 1, 0, 4'h0, 4'h0);
    for (int n = 1; n <= 12; n++) begin
      cyc(0, 1, 0, (n == 5) ? 4'h1 : 4'h0, (n == 6) ? 4'h8 : 4'h0);
      if (obs !== m_outs()) begin
        errors++; $display("FAIL ignored clk %0d got %h exp %h", n, obs, m_outs());
      end
      checks++;
      if (n == 8 || n == 12) begin
        if (mode_o !== 16'h4444) begin
          errors++; $display("FAIL ignored_mode clk %0d got %h exp 4444", n, mode_o);
        end
        checks++;
      end
    end
  endtask

  task automatic test_permanent();
    cyc(1, 1, 0, 4'h0, 4'h0);
    for (int n = 1; n <= 640; n++) begin
      cyc(0, 1, 0, 4'h0, 4'h0);
      if (obs !== m_outs()) begin
        errors++; $display("FAIL permanent clk %0d got %h exp %h", n, obs, m_outs());
      end
      checks++;
      if (n >= 356 && rotate_o !== 4'h0) begin
        errors++; $display("FAIL late_rotate clk %0d got %h exp 0", n, rotate_o);
      end
      if (n >= 356) checks++;
    end
    if ({phase_o, mode_o} !== {3'd3, 16'h8888}) begin
      errors++; $display("FAIL permanent_end got %0d/%h exp 3/8888", phase_o, mode_o);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    cyc(1, 1, 0, 4'h0, 4'h0);
    for (int n = 1; n <= 6; n++) cyc(0, 1, (n == 2) || (n == 6), 4'h0, 4'h0);
    cyc(1, 1, 0, 4'h0, 4'h0);
    if (obs !== RST_OBS) begin
      errors++; $display("FAIL mid_reset got %h exp %h", obs, RST_OBS);
    end
    checks++;
    for (int n = 1; n <= 12; n++) begin
      cyc(0, 1, 0, 4'h0, 4'h0);
      if (obs !== m_outs()) begin
        errors++; $display("FAIL post_reset clk %0d got %h exp %h", n, obs, m_outs());
      end
      checks++;
      if (n == 4 && {mode_o, fright_o} !== {16'h4444, 1'b0}) begin
        errors++; $display("FAIL stale_pellet got %h/%b exp 4444/0", mode_o, fright_o);
      end
      if (n == 4) checks++;
    end
  endtask

  task automatic test_random();
    bit r, en, p;
    bit [3:0] e, h;
    cyc(1, 1, 0, 4'h0, 4'h0);
    for (int n = 1; n <= 5000; n++) begin
      r  = ($urandom_range(0, 1499) == 0);
      en = ($urandom_range(0, 7) != 0);
      p  = ($urandom_range(0, 69) == 0);
      for (int g = 0; g < 4; g++) begin
        e[g] = ($urandom_range(0, 5) == 0);
        h[g] = ($urandom_range(0, 5) == 0);
      end
      cyc(r, en, p, e, h);
      if (obs !== m_outs()) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", n, obs, m_outs());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_schedule();
    test_pellet();
    test_eaten();
    test_ignored_eaten();
    test_permanent();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
